cdb_broadcaster: RTL

Collects completed results from the functional units and drives the Common Data Bus (CDB) that the reservation stations and the register ready table snoop. Each FU port feeds a small per-port FIFO. An arbiter grants at most one result per cycle. The winner is broadcast as a registered tag/data pair plus a one-hot physical-register ready mask, so consumers can set ready bits directly from the mask.

---
 rtl/cdb_broadcaster.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - Common Data Bus broadcaster: per-FU result FIFOs, single-winner arbiter, registered CDB output
//
// Purpose:
//   Buffers completed results from NUM_FU functional units in small per-port
//   FIFOs. Each cycle it pops at most one head entry and registers it onto the
//   CDB as tag/data plus a one-hot ready mask for the physical register file.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   flush      synchronous squash of all buffered and outgoing results
//   fu_valid   per-port result valid
//   fu_tag     per-port destination tag, port i at [i*PREG_W +: PREG_W]
//   fu_data    per-port result data, port i at [i*XLEN +: XLEN]
//   fu_ready   per-port FIFO has room (registered count only)
//   cdb_valid  broadcast valid this cycle
//   cdb_tag    broadcast destination tag
//   cdb_data   broadcast value
//   cdb_mask   one-hot of cdb_tag when cdb_valid, else zero
//
// Configuration:
//   CDB_RR_ARB_EN  defined: round-robin arbitration with a rotating pointer
//                  undefined: fixed priority, lowest port index wins

module cdb_broadcaster #(
  parameter int NUM_FU     = 4,
  parameter int XLEN       = 32,
  parameter int PREG_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*PREG_W-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]   fu_data,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [PREG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]          cdb_data,
  output logic [(1<<PREG_W)-1:0]   cdb_mask
);

  localparam int MASK_W = 1 << PREG_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Per-port FIFO storage and bookkeeping
  logic [PREG_W-1:0] tag_mem  [NUM_FU][FIFO_DEPTH];
  logic [XLEN-1:0]   data_mem [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [NUM_FU];
  logic [PTR_W-1:0]  rd_ptr   [NUM_FU];
  logic [CNT_W-1:0]  count    [NUM_FU];

  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;

  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;
  logic [PREG_W-1:0] head_tag;
  logic [XLEN-1:0]   head_data;
  logic [MASK_W-1:0] head_mask;

  // Ready depends on registered count only: a full FIFO stays not-ready even
  // while it is being popped. Tag 0 is handshaked but never stored.
  always_comb begin
    fu_ready = '0;
    nonempty = '0;
    push     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
      nonempty[i] = (count[i] != '0);
      push[i]     = fu_valid[i] && fu_ready[i] && !flush &&
                    (fu_tag[i*PREG_W +: PREG_W] != '0);
    end
  end

`ifdef CDB_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr;
  int               rr_j;

  // Search from rr_ptr upward with wrap; iterating offsets downward lets the
  // smallest offset (closest to the pointer) be the final assignment.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_j      = 0;
    for (int off = NUM_FU - 1; off >= 0; off--) begin
      rr_j = int'(rr_ptr) + off;
      if (rr_j >= NUM_FU) rr_j = rr_j - NUM_FU;
      if (nonempty[rr_j]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(rr_j);
      end
    end
  end

  // Pointer advances only on an actual pop, so a flushed grant does not move it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any && !flush) begin
      if (int'(grant_idx) == NUM_FU - 1) rr_ptr <= '0;
      else                               rr_ptr <= grant_idx + IDX_W'(1);
    end
  end
`else
  // Fixed priority: lowest-index non-empty port wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (nonempty[i]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    pop = '0;
    if (grant_any && !flush) pop[grant_idx] = 1'b1;
  end

  // Head of the winning FIFO and its one-hot mask. Stored tags are never 0,
  // so mask bit 0 can never be set.
  always_comb begin
    head_tag  = tag_mem[grant_idx][rd_ptr[grant_idx]];
    head_data = data_mem[grant_idx][rd_ptr[grant_idx]];
    head_mask = '0;
    head_mask[head_tag] = 1'b1;
  end

  // FIFO storage has no reset; only slots below count are ever read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]]  <= fu_tag[i*PREG_W +: PREG_W];
        data_mem[i][wr_ptr[i]] <= fu_data[i*XLEN +: XLEN];
      end
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Registered CDB output; tag/data hold their last value while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_mask  <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      cdb_mask  <= '0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= head_tag;
      cdb_data  <= head_data;
      cdb_mask  <= head_mask;
    end else begin
      cdb_valid <= 1'b0;
      cdb_mask  <= '0;
    end
  end

endmodule
